// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and sequencer for a single-ported, byte-addressed data
// memory that acts on the falling clock edge (one read or one write per
// cycle). Port 0 is the processor load/store path, port 1 the loader/DMA
// path. One requester is granted at a time. Misaligned or out-of-range
// accesses are rejected without touching memory.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin tie breaking (reset favours 0)
//                   undefined -> fixed priority, port 0 always wins ties
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req0/req1             access request per port
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           byte address
//   wdata0/wdata1         write data
//   gnt0/gnt1             one-cycle pulse: request accepted, inputs latched
//   done0/done1           one-cycle pulse: access complete
//   err0/err1             high together with done when access was rejected
//   rdata                 read word, valid while any done is high
//   mem_address           memory address
//   mem_write_data        memory write data
//   mem_read, mem_write   memory strobes (never both high)
//   mem_read_data         memory read data (produced at the negedge)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  // Highest legal word-aligned byte address.
  localparam logic [31:0] LAST_ADDR = 32'(4 * MEM_WORDS - 4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        port_q;       // port index of the command in flight
  logic        we_q;         // direction of the command in flight
  logic        prio_q;       // 1 = port 1 wins the next tie
  logic        gnt0_q, gnt1_q;
  logic        done0_q, done1_q;
  logic        err0_q, err1_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic        mem_read_q, mem_write_q;

  // Arbitration result for the current inputs; only used on cycles where
  // the FSM is able to accept a new command (IDLE or RESP).
  logic        win_d;
  logic        sel_we_d;
  logic [31:0] sel_addr_d;
  logic [31:0] sel_wdata_d;
  logic        valid_d;
  logic        prio_d;

  always_comb begin
    win_d       = (req0 && req1) ? prio_q : req1;
    sel_we_d    = win_d ? we1    : we0;
    sel_addr_d  = win_d ? addr1  : addr0;
    sel_wdata_d = win_d ? wdata1 : wdata0;
    valid_d     = (sel_addr_d[1:0] == 2'b00) && (sel_addr_d <= LAST_ADDR);
`ifdef DMEM_ARB_RR_EN
    // The port just granted yields the next tie.
    prio_d      = ~win_d;
`else
    prio_d      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      port_q           <= 1'b0;
      we_q             <= 1'b0;
      prio_q           <= 1'b0;
      gnt0_q           <= 1'b0;
      gnt1_q           <= 1'b0;
      done0_q          <= 1'b0;
      done1_q          <= 1'b0;
      err0_q           <= 1'b0;
      err1_q           <= 1'b0;
      rdata_q          <= 32'd0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      // All handshake pulses and strobes last a single cycle.
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;

      case (state_q)
        ST_ACCESS: begin
          // Memory has acted at the mid-cycle negedge; close the access.
          state_q <= ST_RESP;
          done0_q <= ~port_q;
          done1_q <= port_q;
          if (!we_q) begin
            rdata_q <= mem_read_data;
          end
        end

        default: begin
          // IDLE and RESP both arbitrate, so back-to-back commands never
          // pass through IDLE.
          if (req0 || req1) begin
            port_q <= win_d;
            we_q   <= sel_we_d;
            prio_q <= prio_d;
            gnt0_q <= ~win_d;
            gnt1_q <= win_d;
            if (valid_d) begin
              state_q          <= ST_ACCESS;
              mem_address_q    <= sel_addr_d;
              mem_write_data_q <= sel_wdata_d;
              mem_read_q       <= ~sel_we_d;
              mem_write_q      <= sel_we_d;
            end else begin
              // Rejected: respond immediately, memory is never strobed.
              state_q <= ST_RESP;
              done0_q <= ~win_d;
              done1_q <= win_d;
              err0_q  <= ~win_d;
              err1_q  <= win_d;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt0           = gnt0_q;
  assign gnt1           = gnt1_q;
  assign done0          = done0_q;
  assign done1          = done1_q;
  assign err0           = err0_q;
  assign err1           = err1_q;
  assign rdata          = rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;

endmodule
